// File: rtl/soc_system_pio_edge_in.sv
// Avalon-MM PIO input with 2-flop synchronizer, edge capture (W1C) and masked level irq.
// Latency: in_port -> data register 2 clocks, -> edge_capture/irq 3 clocks; reads are zero-wait.
// Backpressure: none; slave always accepts, reads have no side effects.
module soc_system_pio_edge_in #(
  parameter int WIDTH     = 32,
  parameter int EDGE_TYPE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  logic [WIDTH-1:0] sync1_q, sync1_d;
  logic [WIDTH-1:0] sync2_q, sync2_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] irq_mask_q, irq_mask_d;
  logic [WIDTH-1:0] edge_capture_q, edge_capture_d;

  logic [WIDTH-1:0] edge_event;
  logic [WIDTH-1:0] clear_bits;
  logic             wr_en;
  logic             unused_writedata;

  // Upper writedata bits are ignored when WIDTH < 32.
  assign unused_writedata = ^writedata;

  assign wr_en = chipselect && !write_n;

  // Per-bit edge detect between the synchronized value and its previous sample.
  always_comb begin
    edge_event = '0;
    case (EDGE_TYPE)
      0:       edge_event = sync2_q & ~prev_q;
      1:       edge_event = ~sync2_q & prev_q;
      default: edge_event = sync2_q ^ prev_q;
    endcase
  end

  // Next-state: sync pipeline, mask load, capture with set winning over write-1-clear.
  always_comb begin
    sync1_d        = in_port;
    sync2_d        = sync1_q;
    prev_d         = sync2_q;
    irq_mask_d     = irq_mask_q;
    clear_bits     = '0;
    if (wr_en && address == 2'd2) begin
      irq_mask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && address == 2'd3) begin
      clear_bits = writedata[WIDTH-1:0];
    end
    edge_capture_d = (edge_capture_q & ~clear_bits) | edge_event;
  end

  // State registers; reset drops everything, including any capture in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      prev_q         <= '0;
      irq_mask_q     <= '0;
      edge_capture_q <= '0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      prev_q         <= prev_d;
      irq_mask_q     <= irq_mask_d;
      edge_capture_q <= edge_capture_d;
    end
  end

  // Zero-wait read mux; unused upper bits read as zero.
  always_comb begin
    readdata = '0;
    case (address)
      2'd0:    readdata[WIDTH-1:0] = sync2_q;
      2'd2:    readdata[WIDTH-1:0] = irq_mask_q;
      2'd3:    readdata[WIDTH-1:0] = edge_capture_q;
      default: readdata = '0;
    endcase
  end

  assign irq = |(edge_capture_q & irq_mask_q);

endmodule

// File: tb/tb_soc_system_pio_edge_in.sv
// Bench for soc_system_pio_edge_in: four instances (rising/falling/any at WIDTH 32, rising at WIDTH 8)
// share one bus and are checked against a sample-history reference model.
// Stimulus is directed per feature followed by a randomized bus/input phase.
module tb_soc_system_pio_edge_in;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] in_port;
  logic [31:0] rd0, rd1, rd2, rd3;
  logic        irq0, irq1, irq2, irq3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  soc_system_pio_edge_in #(.WIDTH(32), .EDGE_TYPE(0)) dut0 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port), .readdata(rd0), .irq(irq0));
  soc_system_pio_edge_in #(.WIDTH(32), .EDGE_TYPE(1)) dut1 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port), .readdata(rd1), .irq(irq1));
  soc_system_pio_edge_in #(.WIDTH(32), .EDGE_TYPE(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port), .readdata(rd2), .irq(irq2));
  soc_system_pio_edge_in #(.WIDTH(8), .EDGE_TYPE(0)) dut3 (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .write_n(write_n), .writedata(writedata), .in_port(in_port[7:0]), .readdata(rd3), .irq(irq3));

  // ---------------- reference model ----------------
  // h0/h1/h2: in_port as sampled at the last, second-to-last and third-to-last clock edge.
  logic [31:0] h0, h1, h2;
  logic [31:0] m_cap [4];
  logic [31:0] m_mask[4];

  function automatic int kind_of(int i);
    case (i)
      1:       return 1;
      2:       return 2;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] width_mask(int i);
    return (i == 3) ? 32'h0000_00FF : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] edges(int kind, logic [31:0] now_v, logic [31:0] old_v);
    case (kind)
      0:       return now_v & ~old_v;
      1:       return ~now_v & old_v;
      default: return now_v ^ old_v;
    endcase
  endfunction

  // A value sampled at edge N is seen by software after N+1 and compared with its
  // predecessor into the capture register at N+2.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      h0 = '0; h1 = '0; h2 = '0;
      for (int i = 0; i < 4; i++) begin
        m_cap[i]  = '0;
        m_mask[i] = '0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        logic [31:0] clr;
        clr = (chipselect && !write_n && address == 2'd3) ? writedata : 32'h0;
        m_cap[i] = ((m_cap[i] & ~clr) | edges(kind_of(i), h1, h2)) & width_mask(i);
        if (chipselect && !write_n && address == 2'd2)
          m_mask[i] = writedata & width_mask(i);
      end
      h2 = h1;
      h1 = h0;
      h0 = in_port;
    end
  end

  function automatic logic [31:0] exp_rd(int i, logic [1:0] a);
    case (a)
      2'd0:    return h1 & width_mask(i);
      2'd2:    return m_mask[i];
      2'd3:    return m_cap[i];
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic exp_irq(int i);
    return |(m_cap[i] & m_mask[i]);
  endfunction

  function automatic logic [31:0] obs_rd(int i);
    case (i)
      0:       return rd0;
      1:       return rd1;
      2:       return rd2;
      default: return rd3;
    endcase
  endfunction

  function automatic logic obs_irq(int i);
    case (i)
      0:       return irq0;
      1:       return irq1;
      2:       return irq2;
      default: return irq3;
    endcase
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'h0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1;
    write_n    = 1'b0;
    address    = a;
    writedata  = d;
    tick();
    idle();
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset_n = 1'b0;
    in_port = 32'h0;
    address = 2'd0;
    idle();
    ticks(3);
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      for (int i = 0; i < 4; i++) begin
        total++;
        if (obs_rd(i) !== 32'h0) begin
          bad++;
          $display("FAIL reset_rd dut%0d addr%0d got %h want %h", i, a, obs_rd(i), 32'h0);
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs_irq(i) !== 1'b0) begin
        bad++;
        $display("FAIL reset_irq dut%0d got %b want 0", i, obs_irq(i));
      end
    end
    reset_n = 1'b1;
    ticks(4);
  endtask

  task automatic test_rise_latency();
    wr(2'd3, 32'hFFFF_FFFF);
    in_port = 32'h0000_00A5;
    address = 2'd0;
    tick();
    total++;
    if (rd0 !== 32'h0) begin
      bad++;
      $display("FAIL rise_data_early got %h want %h", rd0, 32'h0);
    end
    tick();
    total++;
    if (rd0 !== 32'h0000_00A5) begin
      bad++;
      $display("FAIL rise_data got %h want %h", rd0, 32'hA5);
    end
    address = 2'd3;
    #1;
    total++;
    if (rd0 !== 32'h0) begin
      bad++;
      $display("FAIL rise_cap_early got %h want %h", rd0, 32'h0);
    end
    tick();
    total++;
    if (rd0 !== 32'h0000_00A5 || irq0 !== 1'b0) begin
      bad++;
      $display("FAIL rise_cap got %h/%b want %h/0", rd0, irq0, 32'hA5);
    end
    for (int i = 1; i < 4; i++) begin
      total++;
      if (obs_rd(i) !== exp_rd(i, 2'd3)) begin
        bad++;
        $display("FAIL rise_cap_model dut%0d got %h want %h", i, obs_rd(i), exp_rd(i, 2'd3));
      end
    end
  endtask

  task automatic test_irq();
    in_port = 32'h0;
    ticks(4);
    wr(2'd3, 32'hFFFF_FFFF);
    wr(2'd2, 32'h0000_0001);
    in_port = 32'h0000_0001;
    ticks(2);
    total++;
    if (irq0 !== 1'b0) begin
      bad++;
      $display("FAIL irq_early got %b want 0", irq0);
    end
    tick();
    total++;
    if (irq0 !== 1'b1) begin
      bad++;
      $display("FAIL irq_set got %b want 1", irq0);
    end
    for (int i = 1; i < 4; i++) begin
      total++;
      if (obs_irq(i) !== exp_irq(i)) begin
        bad++;
        $display("FAIL irq_model dut%0d got %b want %b", i, obs_irq(i), exp_irq(i));
      end
    end
    wr(2'd3, 32'h0000_0001);
    address = 2'd3;
    #1;
    total++;
    if (irq0 !== 1'b0 || rd0 !== 32'h0) begin
      bad++;
      $display("FAIL irq_clear got %b/%h want 0/%h", irq0, rd0, 32'h0);
    end
  endtask

  task automatic test_set_priority();
    wr(2'd3, 32'hFFFF_FFFF);
    in_port = 32'h0000_0005;
    ticks(2);
    wr(2'd3, 32'h0000_0004);
    address = 2'd3;
    #1;
    total++;
    if (rd0[2] !== 1'b1 || rd0 !== exp_rd(0, 2'd3)) begin
      bad++;
      $display("FAIL set_priority got %h want bit2 set (%h)", rd0, exp_rd(0, 2'd3));
    end
    wr(2'd3, 32'h0000_0004);
    address = 2'd3;
    #1;
    total++;
    if (rd0 !== 32'h0) begin
      bad++;
      $display("FAIL clear_after got %h want %h", rd0, 32'h0);
    end
  endtask

  task automatic test_falling_any();
    in_port = 32'h0000_00FF;
    ticks(4);
    wr(2'd3, 32'hFFFF_FFFF);
    in_port = 32'h0000_000F;
    ticks(3);
    address = 2'd3;
    #1;
    total++;
    if (rd1 !== 32'h0000_00F0 || rd2 !== 32'h0000_00F0 || rd0 !== 32'h0) begin
      bad++;
      $display("FAIL fall_any got r%h f%h a%h want 0/f0/f0", rd0, rd1, rd2);
    end
    in_port = 32'h0000_00FF;
    ticks(3);
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs_rd(i) !== exp_rd(i, 2'd3)) begin
        bad++;
        $display("FAIL fall_any_back dut%0d got %h want %h", i, obs_rd(i), exp_rd(i, 2'd3));
      end
    end
    total++;
    if (rd1 !== 32'h0000_00F0) begin
      bad++;
      $display("FAIL fall_hold got %h want %h", rd1, 32'hF0);
    end
  endtask

  task automatic test_reset_mid();
    wr(2'd2, 32'hFFFF_FFFF);
    in_port = 32'h0;
    ticks(4);
    wr(2'd3, 32'hFFFF_FFFF);
    in_port = 32'h0000_FFFF;
    ticks(3);
    total++;
    if (irq0 !== 1'b1) begin
      bad++;
      $display("FAIL mid_irq_pre got %b want 1", irq0);
    end
    in_port = 32'hFFFF_0000;
    tick();
    reset_n = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      total++;
      if (obs_irq(i) !== 1'b0) begin
        bad++;
        $display("FAIL mid_irq dut%0d got %b want 0", i, obs_irq(i));
      end
    end
    for (int a = 0; a < 4; a++) begin
      address = 2'(a);
      #1;
      for (int i = 0; i < 4; i++) begin
        total++;
        if (obs_rd(i) !== 32'h0) begin
          bad++;
          $display("FAIL mid_rd dut%0d addr%0d got %h want %h", i, a, obs_rd(i), 32'h0);
        end
      end
    end
    ticks(2);
    reset_n = 1'b1;
    address = 2'd3;
    ticks(2);
    total++;
    if (rd0 !== 32'h0) begin
      bad++;
      $display("FAIL release_early got %h want %h", rd0, 32'h0);
    end
    tick();
    total++;
    if (rd0 !== 32'hFFFF_0000 || rd3 !== 32'h0 || irq0 !== 1'b0) begin
      bad++;
      $display("FAIL release_cap got %h/%h/%b want ffff0000/0/0", rd0, rd3, irq0);
    end
    address = 2'd1;
    #1;
    total++;
    if (rd0 !== 32'h0) begin
      bad++;
      $display("FAIL addr1 got %h want %h", rd0, 32'h0);
    end
  endtask

  task automatic test_width8();
    wr(2'd2, 32'hFFFF_FFFF);
    address = 2'd2;
    #1;
    total++;
    if (rd3 !== 32'h0000_00FF || rd0 !== 32'hFFFF_FFFF) begin
      bad++;
      $display("FAIL width8_mask got %h/%h want 000000ff/ffffffff", rd3, rd0);
    end
    chipselect = 1'b0;
    write_n    = 1'b0;
    writedata  = 32'h0;
    tick();
    chipselect = 1'b1;
    write_n    = 1'b1;
    tick();
    idle();
    total++;
    if (rd3 !== 32'h0000_00FF) begin
      bad++;
      $display("FAIL no_select_write got %h want %h", rd3, 32'hFF);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 3))
        0:       in_port = $urandom;
        1:       in_port = in_port ^ (32'h1 << $urandom_range(0, 31));
        default: ;
      endcase
      chipselect = 1'($urandom_range(0, 1));
      write_n    = 1'($urandom_range(0, 1));
      address    = 2'($urandom_range(0, 3));
      writedata  = $urandom & $urandom;
      #1;
      for (int i = 0; i < 4; i++) begin
        total++;
        if (obs_rd(i) !== exp_rd(i, address) || obs_irq(i) !== exp_irq(i)) begin
          bad++;
          $display("FAIL random n%0d dut%0d addr%0d got %h/%b want %h/%b",
                   n, i, address, obs_rd(i), obs_irq(i), exp_rd(i, address), exp_irq(i));
        end
      end
      tick();
    end
    idle();
  endtask

  initial begin
    test_reset();
    test_rise_latency();
    test_irq();
    test_set_priority();
    test_falling_any();
    test_reset_mid();
    test_width8();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
